// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if: imem request/response, decode handshake and redirect bundle
interface riscv_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, fetch_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, fetch_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: sequential instruction prefetch with credit-limited FIFO and redirect flush
module riscv_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic               clk,
    input logic               rst,
    riscv_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);
    logic [31:0]   pc;
    logic [31:0]   fetch_count;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   addr_q  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, aq_wr, aq_rd;
    logic [CW-1:0] count, outstanding, discard;
    logic          accept, resp, push, pop;

    // credit rule: buffered + in-flight never exceeds DEPTH, so a push can never overflow
    assign bus.imem_req_valid = !rst && !bus.redirect && ({1'b0, count} + {1'b0, outstanding} < CAP);
    assign bus.imem_req_addr  = pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign resp               = bus.imem_resp_valid;
    assign push               = resp && discard == '0 && !bus.redirect;
    assign bus.if_valid       = count != '0;
    assign bus.if_instr       = bus.if_valid ? instr_q[rd_ptr] : 32'h0000_0013;
    assign bus.if_pc          = bus.if_valid ? pc_q[rd_ptr] : 32'h0;
    assign bus.fetch_count    = fetch_count;
    assign pop                = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk) begin
        if (accept) addr_q[aq_wr] <= pc;
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_resp_data;
            pc_q[wr_ptr]    <= addr_q[aq_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (accept) begin
                pc    <= pc + 32'd4;
                aq_wr <= aq_wr + AW'(1);
            end
            if (resp) aq_rd <= aq_rd + AW'(1);
            if (bus.redirect) begin
                pc      <= bus.redirect_pc & ~32'd3;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                discard <= outstanding - CW'(resp);
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (resp && discard != '0) discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, count} + {1'b0, outstanding} <= CAP);
            assert (discard <= outstanding);
            assert (!(resp && outstanding == '0));
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed checks of fetch flow, back-pressure, redirect and reset
module tb_riscv_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 1;
    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t mq[$];

    riscv_fetch_unit_if a ();
    riscv_fetch_unit_if b ();

    riscv_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst(rst), .bus(a.master));
    riscv_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0200)) dut2 (.clk(clk), .rst(rst), .bus(b.master));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock cycle: memory drives due response, records accepted request, advances past posedge
    task automatic step();
        if (rst) mq.delete();
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            a.imem_resp_valid = 1'b1;
            a.imem_resp_data  = mq[0].addr;
            void'(mq.pop_front());
        end else begin
            a.imem_resp_valid = 1'b0;
            a.imem_resp_data  = 32'hdead_beef;
        end
        @(negedge clk);
        if (a.imem_req_valid && a.imem_req_ready) mq.push_back('{a.imem_req_addr, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a.if_ready = 1'b0;
        a.redirect = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        a.imem_req_ready = 1'b1;
        a.imem_resp_valid = 1'b0;
        a.imem_resp_data = 32'h0;
        a.if_ready = 1'b0;
        a.redirect = 1'b0;
        a.redirect_pc = 32'h0;
        b.imem_req_ready = 1'b1;
        b.imem_resp_valid = 1'b0;
        b.imem_resp_data = 32'h0;
        b.if_ready = 1'b0;
        b.redirect = 1'b0;
        b.redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_if_valid", {31'b0, a.if_valid}, 32'h0);
        chk("rst_if_instr", a.if_instr, 32'h0000_0013);
        chk("rst_if_pc", a.if_pc, 32'h0);
        chk("rst_fetch_count", a.fetch_count, 32'h0);
        chk("rst_req_valid", {31'b0, a.imem_req_valid}, 32'h0);

        // 1-cycle memory, decode always ready
        lat = 1;
        rst = 1'b0;
        a.if_ready = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, a.imem_req_valid}, 32'h1);
        chk("first_req_addr", a.imem_req_addr, 32'h0);
        chk("reset_pc_200_addr", b.imem_req_addr, 32'h200);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stream_valid", {31'b0, a.if_valid}, 32'h1);
            chk("stream_pc", a.if_pc, 32'(4 * i));
            chk("stream_instr", a.if_instr, 32'(4 * i));
            step();
        end
        chk("stream_fetch_count", a.fetch_count, 32'd10);

        // decode stall fills the buffer, then drains with no gap
        do_reset();
        for (int i = 0; i < 6; i++) step();
        chk("stall_valid", {31'b0, a.if_valid}, 32'h1);
        chk("stall_pc", a.if_pc, 32'h0);
        chk("stall_req_valid", {31'b0, a.imem_req_valid}, 32'h0);
        chk("stall_fetch_count", a.fetch_count, 32'h0);
        a.if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", {31'b0, a.if_valid}, 32'h1);
            chk("drain_pc", a.if_pc, 32'(4 * i));
            step();
        end

        // 3-cycle memory, redirect with 3 requests outstanding
        lat = 3;
        do_reset();
        step();
        step();
        step();
        a.redirect = 1'b1;
        a.redirect_pc = 32'h100;
        #1;
        chk("redir_req_valid", {31'b0, a.imem_req_valid}, 32'h0);
        step();
        a.redirect = 1'b0;
        #1;
        chk("post_redir_req_valid", {31'b0, a.imem_req_valid}, 32'h1);
        chk("post_redir_addr", a.imem_req_addr, 32'h100);
        chk("discard_two", 32'(dut.discard), 32'h2);
        chk("stale_drop_c4", {31'b0, a.if_valid}, 32'h0);
        step();
        chk("stale_drop_c5", {31'b0, a.if_valid}, 32'h0);
        step();
        chk("stale_drop_c6", {31'b0, a.if_valid}, 32'h0);
        chk("discard_zero", 32'(dut.discard), 32'h0);
        step();
        chk("stale_drop_c7", {31'b0, a.if_valid}, 32'h0);
        step();
        chk("redir_head_valid", {31'b0, a.if_valid}, 32'h1);
        chk("redir_head_pc", a.if_pc, 32'h100);
        chk("redir_head_instr", a.if_instr, 32'h100);

        // redirect coincident with a response and a decode handshake
        lat = 1;
        do_reset();
        a.if_ready = 1'b1;
        step();
        step();
        chk("coinc_head_pc", a.if_pc, 32'h0);
        a.redirect = 1'b1;
        a.redirect_pc = 32'h103;
        #1;
        chk("coinc_req_valid", {31'b0, a.imem_req_valid}, 32'h0);
        step();
        a.redirect = 1'b0;
        #1;
        chk("coinc_fifo_empty", {31'b0, a.if_valid}, 32'h0);
        chk("coinc_fetch_count", a.fetch_count, 32'h1);
        chk("coinc_aligned_addr", a.imem_req_addr, 32'h100);
        step();
        step();
        chk("coinc_new_pc", a.if_pc, 32'h100);
        a.if_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_valid", {31'b0, a.if_valid}, 32'h1);
        chk("pre_reset_count", a.fetch_count, 32'h1);

        // reset pulse mid-stream with entries buffered
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, a.if_valid}, 32'h0);
        chk("mid_rst_instr", a.if_instr, 32'h0000_0013);
        chk("mid_rst_pc", a.if_pc, 32'h0);
        chk("mid_rst_count", a.fetch_count, 32'h0);
        chk("mid_rst_req_valid", {31'b0, a.imem_req_valid}, 32'h1);
        chk("mid_rst_req_addr", a.imem_req_addr, 32'h0);
        chk("mid_rst_pc200", b.imem_req_addr, 32'h200);
        step();
        step();
        chk("mid_rst_first_pc", a.if_pc, 32'h0);
        chk("mid_rst_first_valid", {31'b0, a.if_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction-fetch front end for the pipelined RISC-V core. It sits directly upstream of the IF/ID pipeline register. It generates sequential word addresses to the instruction memory and buffers returned instructions in a small prefetch FIFO. It presents them to decode with a valid/ready handshake, so that a decode stall does not stop outstanding fetches. A redirect input flushes the buffer, retargets the PC and discards stale in-flight responses.

## Interface
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2; also the cap on buffered + outstanding fetches
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request this cycle
- `imem_req_addr` out 32: byte address of requested word, bits [1:0] always 0
- `imem_resp_valid` in 1: instruction word returning; in request order, ≥1 cycle after acceptance, never back-pressured
- `imem_resp_data` in 32: returned instruction
- `if_valid` out 1: head FIFO entry valid for decode
- `if_ready` in 1: decode consumes head this cycle
- `if_instr` out 32: head instruction; 32'h0000_0013 (NOP) when `if_valid`=0
- `if_pc` out 32: byte address of `if_instr`; 0 when `if_valid`=0
- `redirect` in 1: flush and retarget
- `redirect_pc` in 32: new fetch address; bits [1:0] forced to 0
- `fetch_count` out 32: number of if_valid&&if_ready handshakes since reset, wraps

## Operation
- State: `pc` (next fetch address), FIFO of {instr, pc} pairs, `outstanding` (accepted requests not yet returned), `discard` (returns still to be dropped), `fetch_count`.
- Request issue: `imem_req_valid` = !rst && !redirect && (occupancy + outstanding < DEPTH). `imem_req_addr` = `pc`. On accept (valid && ready): `pc` <= `pc`+4 (mod 2^32), `outstanding`++.
- Each request records its own address. Return order equals issue order, so the FIFO entry pc comes from a DEPTH-deep address queue written on accept and popped on response.
- Response: `outstanding`--. If `discard`>0, the word is dropped and `discard`--. Otherwise it is pushed to the FIFO tail. The credit rule guarantees the push never overflows.
- Decode handshake: when if_valid && if_ready, the head is popped and `fetch_count`++. Push and pop in the same cycle leave occupancy unchanged.
- Redirect (highest priority):
  - FIFO emptied.
  - `pc` <= {redirect_pc[31:2],2'b00}.
  - `discard` <= `outstanding` after this cycle's response (a response arriving in the redirect cycle is itself dropped).
  - No request is issued in the redirect cycle.
  - A head handshake in the redirect cycle still counts in `fetch_count`.
- Reset: `pc`=RESET_PC, FIFO empty, `outstanding`=0, `discard`=0, `fetch_count`=0. Outputs are `imem_req_valid`=0, `if_valid`=0, `if_instr`=NOP, `if_pc`=0. Reset mid-operation abandons in-flight requests; the memory must also be reset with the same `rst`.
- Asserted invariants: occupancy+outstanding ≤ DEPTH; `discard` ≤ `outstanding`; `imem_resp_valid` never arrives with `outstanding`=0.

## Timing
- First request: cycle after `rst` deasserts.
- `if_valid`, `if_instr` and `if_pc` are registered FIFO-head outputs. A response in cycle N makes its entry visible at cycle N+1 when the FIFO was empty. There is no combinational path from `imem_resp_*` to `if_*`.
- Minimum latency from request accept to decode-visible: 2 cycles with 1-cycle memory.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and DEPTH≥2.
- `imem_req_valid` is combinational from state and `redirect`. It does not depend on `imem_req_ready`.
- Post-redirect: the first new request is issued the cycle after `redirect`, at `redirect_pc`. Stale returns never reach `if_*`.

## Test plan
- Reset, 1-cycle memory returning word = addr, `if_ready`=1 → if_pc sequence 0,4,8,…; if_instr==if_pc; one handshake per cycle from cycle 2; `fetch_count`=10 after 10 handshakes.
- `if_ready`=0 with 1-cycle memory → exactly 4 entries buffered (pcs 0–12), `imem_req_valid` held 0. Then `if_ready`=1 → 0,4,8,12,16 with no gap or duplicate.
- 3-cycle memory latency, 3 requests outstanding, then `redirect`=1 with `redirect_pc`=32'h100 → 3 stale words dropped; first if_pc after redirect = 0x100; `discard` returns to 0.
- `redirect_pc`=32'h103 → `imem_req_addr`=0x100.
- `redirect` coincident with `imem_resp_valid` and with an if_valid&&if_ready handshake → response dropped; `fetch_count` increments by 1; FIFO empty next cycle.
- Reset pulse mid-stream with entries buffered → next cycle if_valid=0, if_instr=32'h13, if_pc=0, fetch_count=0; next fetch at RESET_PC. Repeat with RESET_PC=32'h200 → first `imem_req_addr`=0x200.
